// File: rtl/alu_issue.sv
// alu_issue: single-issue front end for an external one-cycle ALU.
// Holds an 8x32 register file (r0 hardwired to zero), registers operands
// toward the ALU, and writes results back two edges after accept.
// Build option: define ALU_ISSUE_FWD_EN to forward alu_dr into the operand
// outputs on a distance-1 hazard; without it the block stalls one cycle and
// relies on the write-through read path instead.
module alu_issue #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic              in_imm_en,
    input  logic [15:0]       in_imm,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_tr,
    output logic [DATA_W-1:0] alu_sr,
    input  logic [DATA_W-1:0] alu_dr,
    input  logic              alu_cf,
    input  logic              alu_of,
    output logic              wb_valid,
    output logic              flags_cf,
    output logic              flags_of,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] rf [8];
    logic              vld_p1, vld_p2;
    logic [2:0]        rd_p1, rd_p2;
    logic [3:0]        op_p1;
    logic [DATA_W-1:0] tr_p1, sr_p1;
    logic [DATA_W-1:0] rs_val, rt_val, sr_val;
    logic              haz_t, haz_s, accept, wb_en;

    function automatic logic [DATA_W-1:0] sext_imm(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    assign wb_en  = vld_p2 && (rd_p2 != 3'd0);
    assign accept = in_valid && in_ready;

    // Distance-1 hazard: offered instruction reads the nonzero rd still in p1.
    assign haz_t = vld_p1 && (rd_p1 != 3'd0) && (rd_p1 == in_rs);
    assign haz_s = vld_p1 && (rd_p1 != 3'd0) && !in_imm_en && (rd_p1 == in_rt);

    // Operand read with write-through from a writeback on the same edge.
    always_comb begin
        rs_val = rf[in_rs];
        rt_val = rf[in_rt];
        if (wb_en && (rd_p2 == in_rs)) rs_val = alu_dr;
        if (wb_en && (rd_p2 == in_rt)) rt_val = alu_dr;
        sr_val = in_imm_en ? sext_imm(in_imm) : rt_val;
    end

`ifdef ALU_ISSUE_FWD_EN
    logic fwd_t_p1, fwd_s_p1;

    assign in_ready = 1'b1;
    assign alu_tr   = fwd_t_p1 ? alu_dr : tr_p1;
    assign alu_sr   = fwd_s_p1 ? alu_dr : sr_p1;

    // Forward bits live for exactly the cycle after a hazarding accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_t_p1 <= 1'b0;
            fwd_s_p1 <= 1'b0;
        end else begin
            fwd_t_p1 <= accept && haz_t;
            fwd_s_p1 <= accept && haz_s;
        end
    end
`else
    assign in_ready = !(in_valid && (haz_t || haz_s));
    assign alu_tr   = tr_p1;
    assign alu_sr   = sr_p1;
`endif

    assign alu_op   = op_p1;
    assign wb_valid = vld_p2;
    assign dbg_data = rf[dbg_addr];

    // ---- p1 -> p2 boundary: valid and destination index advance each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            rd_p1  <= 3'd0;
            rd_p2  <= 3'd0;
        end else begin
            vld_p1 <= accept;
            vld_p2 <= vld_p1;
            if (accept) rd_p1 <= in_rd;
            rd_p2  <= rd_p1;
        end
    end

    // ---- p0 -> p1 boundary: capture operands on accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p1 <= 4'd0;
            tr_p1 <= '0;
            sr_p1 <= '0;
        end else if (accept) begin
            op_p1 <= in_op;
            tr_p1 <= rs_val;
            sr_p1 <= sr_val;
        end
`ifdef ALU_ISSUE_FWD_EN
        else begin
            // Fold a forwarded value in so the held operand stays what was issued.
            if (fwd_t_p1) tr_p1 <= alu_dr;
            if (fwd_s_p1) sr_p1 <= alu_dr;
        end
`endif
    end

    // ---- p2 writeback: register file and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
            flags_cf <= 1'b0;
            flags_of <= 1'b0;
        end else begin
            if (vld_p2) begin
                flags_cf <= alu_cf;
                flags_of <= alu_of;
            end
            if (wb_en) rf[rd_p2] <= alu_dr;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural one-cycle ALU, architectural register
// model and a result scoreboard checked at every writeback.
module tb_alu_issue;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SLL = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_op = 4'd0;
    logic [2:0]  in_rd = 3'd0, in_rs = 3'd0, in_rt = 3'd0;
    logic        in_imm_en = 1'b0;
    logic [15:0] in_imm = 16'd0;
    logic [3:0]  alu_op;
    logic [31:0] alu_tr, alu_sr;
    logic [31:0] alu_dr = 32'd0;
    logic        alu_cf = 1'b0, alu_of = 1'b0;
    logic        wb_valid, flags_cf, flags_of;
    logic [2:0]  dbg_addr = 3'd0;
    logic [31:0] dbg_data;

    typedef struct {
        logic [31:0] res;
        logic        cf;
        logic        of;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_rf [8];
    int          checks = 0;
    int          errors = 0;
    int          wb_cnt = 0;
    int          run_len = 0;
    int          max_run = 0;
    int          stalls;
    int          exp_stall;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_imm_en(in_imm_en), .in_imm(in_imm),
        .alu_op(alu_op), .alu_tr(alu_tr), .alu_sr(alu_sr),
        .alu_dr(alu_dr), .alu_cf(alu_cf), .alu_of(alu_of),
        .wb_valid(wb_valid), .flags_cf(flags_cf), .flags_of(flags_of),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns {cf, of, result}.
    function automatic logic [33:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        of;
        w = 33'd0; of = 1'b0;
        case (op)
            OP_ADD: begin w = {1'b0, a} + {1'b0, b}; of = (a[31] == b[31]) && (w[31] != a[31]); end
            OP_SUB: begin w = {1'b0, a} - {1'b0, b}; of = (a[31] != b[31]) && (w[31] != a[31]); end
            OP_SLL: w = {1'b0, a} << b[4:0];
            default: w = {1'b0, a ^ b};
        endcase
        r = w[31:0];
        return {w[32], of, r};
    endfunction

    // External ALU: samples operands at an edge, result valid the next cycle.
    always @(posedge clk) begin
        logic [33:0] t;
        t = alu_f(alu_op, alu_tr, alu_sr);
        alu_dr <= t[31:0];
        alu_of <= t[32];
        alu_cf <= t[33];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Writeback monitor: every wb_valid cycle must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            exp_t e;
            wb_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (sb_q.size() == 0) begin
                check("wb_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("wb_result", alu_dr, e.res);
                check("wb_cf", {31'd0, alu_cf}, {31'd0, e.cf});
            end
        end else begin
            run_len = 0;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic ie, input logic [15:0] imm,
                         output int nstall);
        logic        acc;
        logic [31:0] a, b;
        logic [33:0] t;
        exp_t        e;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs = rs; in_rt = rt;
        in_imm_en = ie; in_imm = imm;
        nstall = 0;
        acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            #1;
            acc = in_ready;
            if (!acc) nstall++;
            if (acc) begin
                a = ref_rf[rs];
                b = ie ? {{16{imm[15]}}, imm} : ref_rf[rt];
                t = alu_f(op, a, b);
                e.res = t[31:0]; e.of = t[32]; e.cf = t[33];
                sb_q.push_back(e);
                if (rd != 3'd0) ref_rf[rd] = t[31:0];
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic dbg_check(input string tag, input logic [2:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ref_rf[i] = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_flags", {30'd0, flags_cf, flags_of}, 32'd0);
        check("rst_alu_tr", alu_tr, 32'd0);
        for (int i = 0; i < 8; i++) dbg_check("rst_rf", 3'(i), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Immediate add and its latency
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, stalls);
        check("lat_e1_wb", {31'd0, wb_valid}, 32'd0);
        @(negedge clk);
        check("lat_e2_wb", {31'd0, wb_valid}, 32'd1);
        @(negedge clk);
        dbg_check("imm_r1", 3'd1, 32'd5);
        issue(OP_ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'd9, stalls);
        idle(3);
        dbg_check("imm_r0", 3'd0, 32'd0);

        // Distance-1 hazard
`ifdef ALU_ISSUE_FWD_EN
        exp_stall = 0;
`else
        exp_stall = 1;
`endif
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd7, stalls);
        issue(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b0, 16'd0, stalls);
        check("d1_stalls", 32'(stalls), 32'(exp_stall));
        idle(4);
        dbg_check("d1_r2", 3'd2, 32'd14);

        // Distance-2: second accept lands on the r1 writeback edge
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd3, stalls);
        idle(1);
        issue(OP_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 16'd1, stalls);
        check("d2_stalls", 32'(stalls), 32'd0);
        idle(4);
        dbg_check("d2_r3", 3'd3, 32'd4);

        // Flags from a shift
        issue(OP_ADD, 3'd4, 3'd0, 3'd0, 1'b1, 16'hFFFF, stalls);
        issue(OP_SLL, 3'd5, 3'd4, 3'd0, 1'b1, 16'd1, stalls);
        idle(4);
        dbg_check("sll_r4", 3'd4, 32'hFFFF_FFFF);
        dbg_check("sll_r5", 3'd5, 32'hFFFF_FFFE);
        check("sll_flags_cf", {31'd0, flags_cf}, 32'd1);

        // Throughput: 8 independent back-to-back instructions
        begin
            logic [2:0] rds [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd1, 3'd2};
            logic [3:0] ops [3] = '{OP_ADD, OP_SUB, OP_XOR};
            int tot = 0;
            max_run = 0;
            for (int i = 0; i < 8; i++) begin
                issue(ops[i % 3], rds[i], 3'd5, 3'd0, 1'b1, 16'(i * 3 + 1), stalls);
                tot += stalls;
            end
            idle(4);
            check("tput_stalls", 32'(tot), 32'd0);
            check("tput_run", 32'(max_run), 32'd8);
            for (int i = 1; i < 8; i++) dbg_check("tput_rf", 3'(i), ref_rf[i]);
        end

        // Reset mid-stream
        issue(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'd11, stalls);
        issue(OP_ADD, 3'd7, 3'd0, 3'd0, 1'b1, 16'd12, stalls);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 8; i++) ref_rf[i] = 32'd0;
        #1;
        check("mrst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mrst_flags", {30'd0, flags_cf, flags_of}, 32'd0);
        for (int i = 0; i < 8; i++) dbg_check("mrst_rf", 3'(i), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wb_cnt = 0;
        idle(5);
        check("mrst_no_wb", 32'(wb_cnt), 32'd0);
        issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, stalls);
        idle(4);
        dbg_check("mrst_r1", 3'd1, 32'd5);
        for (int i = 2; i < 8; i++) dbg_check("mrst_rf_post", 3'(i), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 clk  in  1  rising-edge clock shared with the ALU.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 in_valid  in  1  instruction offered this cycle.
REQ-005 in_ready  out  1  instruction accepted when in_valid and in_ready are both high at a rising edge.
REQ-006 in_op  in  4  ALU opcode, forwarded unmodified.
REQ-007 in_rd / in_rs / in_rt  in  3 each  destination, first-source and second-source register indices.
REQ-008 in_imm_en  in  1  when high, sr comes from in_imm instead of in_rt.
REQ-009 in_imm  in  16  immediate, sign-extended to 32 bits.
REQ-010 alu_op  out  4  opcode presented to the ALU.
REQ-011 alu_tr / alu_sr  out  32 each  operands presented to the ALU.
REQ-012 alu_dr  in  32  ALU result; valid in the cycle after the ALU samples its operands.
REQ-013 alu_cf / alu_of  in  1 each  ALU carry and overflow flags, sampled alongside alu_dr.
REQ-014 wb_valid  out  1  high in the cycle a result is being written back.
REQ-015 flags_cf / flags_of  out  1 each  registered flags from the last writeback.
REQ-016 dbg_addr  in  3  debug register-file read index.
REQ-017 dbg_data  out  32  combinational register-file contents at dbg_addr.

Function
REQ-018 The register file SHALL hold 8x32 registers: r0 always reads 0, and writes to r0 are discarded.
REQ-019 On the accept edge E1, the block SHALL register alu_op, tr = R[rs], and sr = (imm_en ? sext(imm) : R[rt]), and set p1_valid.
REQ-020 At edge E2, p1_valid SHALL move to p2_valid; the ALU samples operands at E2, and alu_dr is valid during cycle E2-E3.
REQ-021 wb_valid SHALL equal p2_valid.
REQ-022 At E3, R[rd] <= alu_dr (unless rd = 0) and flags_cf/flags_of <= alu_cf/alu_of.
REQ-023 Register-file reads at accept SHALL be write-through: if a writeback to the same nonzero index occurs on the same edge, the read SHALL return alu_dr.
REQ-024 A distance-1 hazard exists when the offered instruction reads (rs, or rt when not imm_en) the nonzero rd of the p1 instruction.
REQ-025 alu_op/alu_tr/alu_sr SHALL hold their last issued values when no instruction is accepted; results with no valid bit set are never written.
REQ-026 in_ready SHALL be 1 except during a non-forwarding stall (REQ-033).
REQ-027 The block SHALL sustain one accepted instruction per cycle, with 2-edge latency from accept to wb_valid and a register update at the third edge.
REQ-028 Simultaneous accept and writeback SHALL both take effect on the same edge.

Reset
REQ-029 While rst_n is low, the block SHALL clear all registers, p1_valid, p2_valid, alu_op/alu_tr/alu_sr, flags_cf and flags_of to 0, and hold wb_valid at 0 and in_ready at 1.
REQ-030 A reset asserted mid-operation SHALL discard in-flight instructions with no writeback; the first accept after deassertion behaves as in REQ-019.

Configuration
REQ-031 The macro ALU_ISSUE_FWD_EN SHALL select the hazard-handling mode.
REQ-032 With ALU_ISSUE_FWD_EN defined, on a distance-1 hazard the block SHALL record per-operand forward bits at accept, and alu_tr/alu_sr SHALL combinationally select alu_dr during the following cycle, with no stall.
REQ-033 Without ALU_ISSUE_FWD_EN, a distance-1 hazard SHALL drive in_ready low for exactly one cycle; the instruction is then accepted using the write-through read of REQ-023, and no forward muxes exist.

Verification
REQ-034 Reset: assert rst_n = 0 mid-stream -> all dbg_data = 0, flags = 0, wb_valid = 0, in_ready = 1, and no later writeback from pre-reset instructions.
REQ-035 Immediate: ADD r1 = r0 + imm 5 -> wb_valid 2 edges after accept, then dbg r1 = 5; ADD r0 = r0 + imm 9 -> dbg r0 = 0.
REQ-036 Distance-1: ADD r1 = r0 + imm 7, then ADD r2 = r1 + r1 -> r2 = 14; with FWD, in_ready stays 1; without FWD, in_ready = 0 for exactly one cycle.
REQ-037 Distance-2: ADD r1 = imm 3, NOP-gap of one idle cycle, ADD r3 = r1 + imm 1 on the r1 writeback edge -> r3 = 4 with no stall in either mode.
REQ-038 Flags: ADD r4 = imm 0xFFFF, then SLL r5 = r4 by imm 1 -> r5 = 0xFFFFFFFE and flags_cf = 1 after the r5 writeback.
REQ-039 Throughput: 8 back-to-back independent instructions -> 8 consecutive wb_valid cycles with correct values in order.
